// File: rtl/scan_ctrl_pkg.sv
// rtl/scan_ctrl_pkg.sv - shared state encoding and sizing helpers for the scan chain controller
package scan_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    LOAD    = 3'd2,
    CAPTURE = 3'd3,
    UNLOAD  = 3'd4,
    DONE    = 3'd5
  } scan_state_e;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/scan_shift_reg.sv
// rtl/scan_shift_reg.sv - shift register with clear, parallel load, serial LSB in and MSB out
// Clear has priority over load, load over shift.
module scan_shift_reg #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RSTB,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         shift_i,
  input  logic         sin_i,
  output logic [W-1:0] q_o,
  output logic         sout_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge CLK or posedge RSTB) begin
    if (RSTB) begin
      data_q <= '0;
    end else if (clr_i) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= load_val_i;
    end else if (shift_i) begin
      data_q <= {data_q[W-2:0], sin_i};
    end
  end

  assign q_o    = data_q;
  assign sout_o = data_q[W-1];

endmodule

// File: rtl/scan_chain_ctrl.sv
// rtl/scan_chain_ctrl.sv - load/capture/unload sequencer for one mux-D scan chain
// Clears the chain, shifts a pattern in MSB first, runs capture clocks, then unloads.
module scan_chain_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = 16,
  parameter int CNT_W     = cnt_width(CHAIN_LEN),
  parameter int CAP_W     = 4
) (
  input  logic                 CLK,
  input  logic                 RSTB,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic [CAP_W-1:0]     cap_cycles,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] result,
  output logic                 scan_en,
  output logic                 scan_in,
  input  logic                 scan_out,
  output logic                 chain_rstb_n
);

  localparam int               CTR_W    = max_int(CNT_W, CAP_W);
  localparam logic [CTR_W-1:0] LAST_BIT = CTR_W'(CHAIN_LEN - 1);

  scan_state_e          state_q;
  logic [CTR_W-1:0]     cnt_q;
  logic [CAP_W-1:0]     cap_cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 scan_en_q;
  logic                 scan_in_q;
  logic                 chain_rstb_n_q;

  logic                 accept;
  logic                 shift_last;
  logic                 cap_last;
  logic                 pat_sout;
  logic [CHAIN_LEN-1:0] pat_q_unused;
  logic                 res_sout_unused;

  assign accept     = (state_q == IDLE) && start;
  assign shift_last = (cnt_q == LAST_BIT);
  assign cap_last   = (cnt_q == CTR_W'(cap_cnt_q - CAP_W'(1)));

  // Pattern register shifts from CLEAR on so its MSB always holds the next bit to present on scan_in.
  scan_shift_reg #(.W(CHAIN_LEN)) u_pat_sr (
    .CLK        (CLK),
    .RSTB       (RSTB),
    .clr_i      (1'b0),
    .load_i     (accept),
    .load_val_i (pattern),
    .shift_i    ((state_q == CLEAR) || (state_q == LOAD)),
    .sin_i      (1'b0),
    .q_o        (pat_q_unused),
    .sout_o     (pat_sout)
  );

  scan_shift_reg #(.W(CHAIN_LEN)) u_res_sr (
    .CLK        (CLK),
    .RSTB       (RSTB),
    .clr_i      ((state_q == CAPTURE) && cap_last),
    .load_i     (1'b0),
    .load_val_i ('0),
    .shift_i    (state_q == UNLOAD),
    .sin_i      (scan_out),
    .q_o        (result),
    .sout_o     (res_sout_unused)
  );

  always_ff @(posedge CLK or posedge RSTB) begin
    if (RSTB) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      cap_cnt_q      <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      scan_en_q      <= 1'b0;
      scan_in_q      <= 1'b0;
      chain_rstb_n_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q        <= CLEAR;
            cap_cnt_q      <= (cap_cycles == '0) ? CAP_W'(1) : cap_cycles;
            busy_q         <= 1'b1;
            chain_rstb_n_q <= 1'b0;
          end
        end
        CLEAR: begin
          state_q        <= LOAD;
          cnt_q          <= '0;
          chain_rstb_n_q <= 1'b1;
          scan_en_q      <= 1'b1;
          scan_in_q      <= pat_sout;
        end
        LOAD: begin
          if (shift_last) begin
            state_q   <= CAPTURE;
            cnt_q     <= '0;
            scan_en_q <= 1'b0;
            scan_in_q <= 1'b0;
          end else begin
            cnt_q     <= cnt_q + CTR_W'(1);
            scan_in_q <= pat_sout;
          end
        end
        CAPTURE: begin
          if (cap_last) begin
            state_q   <= UNLOAD;
            cnt_q     <= '0;
            scan_en_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CTR_W'(1);
          end
        end
        UNLOAD: begin
          if (shift_last) begin
            state_q   <= DONE;
            cnt_q     <= '0;
            scan_en_q <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CTR_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign scan_en      = scan_en_q;
  assign scan_in      = scan_in_q;
  assign chain_rstb_n = chain_rstb_n_q;

endmodule
